// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if -- request/result bundle between a scan requester and the
// 4:1 mux scan controller.
//   start_in  : scan request (requester -> controller)
//   y_in      : output of the downstream 4:1 mux (mux -> controller)
//   sel_out   : mux select driven by the controller
//   data_out  : assembled word, bit i = y_in sampled while sel_out==i
//   ones_out  : popcount of data_out
//   valid_out : one-cycle pulse when data_out/ones_out are refreshed
//   busy_out  : scan in progress
interface mux_scan_ctrl_if;
  logic       start_in;
  logic       y_in;
  logic [1:0] sel_out;
  logic [3:0] data_out;
  logic [2:0] ones_out;
  logic       valid_out;
  logic       busy_out;

  modport master (
    output start_in, y_in,
    input  sel_out, data_out, ones_out, valid_out, busy_out
  );

  modport slave (
    input  start_in, y_in,
    output sel_out, data_out, ones_out, valid_out, busy_out
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl -- steps a 4:1 mux select through 0..3, lets each select
// settle for SETTLE_CYCLES cycles, samples the mux output into a shadow word,
// then publishes the word and its popcount with a one-cycle valid pulse.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mux_scan_ctrl_if (start/y in, select/result out)
module mux_scan_ctrl #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_scan_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [1:0] sel, sel_d;
  logic [3:0] shadow, shadow_d;
  logic       load;
  logic [3:0] data_q;
  logic [2:0] ones_q;
  logic       valid_q, busy_q;

  function automatic logic [2:0] popcnt(input logic [3:0] w);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) n = n + 3'(w[i]);
    return n;
  endfunction

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    sel_d    = sel;
    shadow_d = shadow;
    load     = 1'b0;
    case (state)
      IDLE: begin
        sel_d = 2'd0;
        if (bus.start_in) begin
          state_d  = SETTLE;
          cnt_d    = '0;
          shadow_d = '0;
        end
      end
      SETTLE: begin
        cnt_d = cnt + 4'd1;
        if (cnt == CNT_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        shadow_d[sel] = bus.y_in;
        if (sel != 2'd3) begin
          sel_d   = sel + 2'd1;
          cnt_d   = '0;
          state_d = SETTLE;
        end else begin
          // publish the word including the bit captured this cycle
          state_d = DONE;
          load    = 1'b1;
        end
      end
      DONE: begin
        // select goes back to 0 explicitly, never by wrapping 3 -> 0
        sel_d = 2'd0;
        if (bus.start_in) begin
          state_d  = SETTLE;
          cnt_d    = '0;
          shadow_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      sel     <= '0;
      shadow  <= '0;
      data_q  <= '0;
      ones_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      sel     <= sel_d;
      shadow  <= shadow_d;
      valid_q <= (state_d == DONE);
      busy_q  <= (state_d == SETTLE) || (state_d == SAMPLE);
      if (load) begin
        data_q <= shadow_d;
        ones_q <= popcnt(shadow_d);
      end
    end
  end

  assign bus.sel_out   = sel;
  assign bus.data_out  = data_q;
  assign bus.ones_out  = ones_q;
  assign bus.valid_out = valid_q;
  assign bus.busy_out  = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl -- directed bench: two controllers (SETTLE_CYCLES 1 and 3)
// each driving a behavioural 4:1 mux over a 4-bit data word.
module tb_mux_scan_ctrl;

  logic clk;
  logic rst_n;
  logic [3:0] data_a, data_b;
  int n_chk, n_fail;

  mux_scan_ctrl_if bus_a ();
  mux_scan_ctrl_if bus_b ();

  mux_scan_ctrl #(.SETTLE_CYCLES(1)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  mux_scan_ctrl #(.SETTLE_CYCLES(3)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // behavioural 4:1 mux in front of each controller
  assign bus_a.y_in = data_a[bus_a.sel_out];
  assign bus_b.y_in = data_b[bus_b.sel_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start_in high across one rising edge (edge T); returns just after T
  task automatic start_a();
    bus_a.start_in = 1'b1;
    tick();
    bus_a.start_in = 1'b0;
  endtask

  // called just after start edge T; ends just after T+8 with DONE checked
  task automatic scan_a(input int exp_data, input int exp_ones, input int prev_data,
                        input bit poke);
    for (int k = 0; k < 8; k++) begin
      chk("sel", bus_a.sel_out, k / 2);
      chk("busy", bus_a.busy_out, 1);
      chk("valid_quiet", bus_a.valid_out, 0);
      if (k == 0) chk("data_hold", bus_a.data_out, prev_data);
      if (poke && k == 3) bus_a.start_in = 1'b1;
      if (poke && k == 5) bus_a.start_in = 1'b0;
      tick();
    end
    chk("valid_done", bus_a.valid_out, 1);
    chk("busy_done", bus_a.busy_out, 0);
    chk("data", bus_a.data_out, exp_data);
    chk("ones", bus_a.ones_out, exp_ones);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    bus_a.start_in = 1'b0;
    bus_b.start_in = 1'b0;
    data_a = 4'b0000;
    data_b = 4'b0000;

    // reset asserted before any clock edge: outputs must already be zero
    rst_n = 1'b0;
    #2;
    chk("rst_sel", bus_a.sel_out, 0);
    chk("rst_data", bus_a.data_out, 0);
    chk("rst_ones", bus_a.ones_out, 0);
    chk("rst_valid", bus_a.valid_out, 0);
    chk("rst_busy", bus_a.busy_out, 0);
    #1 rst_n = 1'b1;
    tick();
    tick();
    chk("idle_busy", bus_a.busy_out, 0);

    // basic scan, 1010
    data_a = 4'b1010;
    start_a();
    scan_a(4'b1010, 2, 0, 1'b0);
    tick();
    chk("single_pulse", bus_a.valid_out, 0);
    chk("idle_sel", bus_a.sel_out, 0);

    // start pulsed while busy must be ignored
    start_a();
    scan_a(4'b1010, 2, 4'b1010, 1'b1);
    tick();
    chk("poke_no_pulse", bus_a.valid_out, 0);
    chk("poke_no_restart", bus_a.busy_out, 0);
    tick();
    chk("poke_still_idle", bus_a.busy_out, 0);

    // reset mid-scan while sel==2
    data_a = 4'b0110;
    start_a();
    for (int k = 0; k < 4; k++) tick();
    chk("pre_rst_sel", bus_a.sel_out, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", bus_a.sel_out, 0);
    chk("mid_rst_data", bus_a.data_out, 0);
    chk("mid_rst_ones", bus_a.ones_out, 0);
    chk("mid_rst_busy", bus_a.busy_out, 0);
    chk("mid_rst_valid", bus_a.valid_out, 0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("post_rst_valid", bus_a.valid_out, 0);
      chk("post_rst_busy", bus_a.busy_out, 0);
    end
    start_a();
    scan_a(4'b0110, 2, 0, 1'b0);

    // back-to-back: restart from DONE with new data
    tick();
    data_a = 4'b1111;
    start_a();
    scan_a(4'b1111, 4, 4'b0110, 1'b0);
    data_a = 4'b0000;
    start_a();
    scan_a(4'b0000, 0, 4'b1111, 1'b0);
    tick();
    chk("b2b_end", bus_a.valid_out, 0);

    // longer settle time on the second controller
    data_b = 4'b0001;
    bus_b.start_in = 1'b1;
    tick();
    bus_b.start_in = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("b_sel", bus_b.sel_out, k / 4);
      chk("b_busy", bus_b.busy_out, 1);
      chk("b_valid_quiet", bus_b.valid_out, 0);
      tick();
    end
    chk("b_valid", bus_b.valid_out, 1);
    chk("b_data", bus_b.data_out, 4'b0001);
    chk("b_ones", bus_b.ones_out, 1);
    tick();
    chk("b_valid_end", bus_b.valid_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
